rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Clocked arbiter sharing the single instruction ROM between the fetch unit and the load/literal-pool path of the memory stage. Both requesters, and the ROM itself, use the two-phase toggle handshake used throughout the core: `trigger` toggles to request, `ready` toggles to complete. The block sits between `fetch`/memory stage and `rom`. It grants round-robin, forwards one access at a time, returns data to the owner and flags a hung ROM with a watchdog.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 64, max cycles a ROM access may remain outstanding; must be ≥2.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fTriggerIn`  in  1  fetch request toggle.
- `fAddrIn`  in  ADDR_W  fetch address; stable while fetch request pending.
- `fDataOut`  out  DATA_W  registered fetch read data.
- `fReadyOut`  out  1  fetch completion toggle.
- `lTriggerIn`, `lAddrIn`, `lDataOut`, `lReadyOut`: load-port equivalents of the four fetch ports.
- `romTriggerOut`  out  1  ROM request toggle.
- `romAddrOut`  out  ADDR_W  registered ROM address.
- `romDataIn`  in  DATA_W  ROM data; valid when ROM ack phase matches.
- `romReadyIn`  in  1  ROM completion toggle.
- `grantLoad`  out  1  owner of current/last access (0 fetch, 1 load).
- `timeoutErr`  out  1  sticky watchdog error.

## Operation
- All inputs are synchronous to `clk`; no synchronizers inside.
- Pending: fetch pending ⇔ `fTriggerIn != fReadyOut`; load likewise. Requester must not toggle again before its ready toggles.
- States: IDLE, WAIT, ERR.
- IDLE: if no pending, hold. If one pending, grant it. If both pending, grant the one not granted last (`grantLoad` holds last owner). On grant edge: `romAddrOut` ← owner address, `romTriggerOut` toggles, `grantLoad` ← owner, watchdog counter ← 0, → WAIT.
- WAIT: ack when `romReadyIn == romTriggerOut`. On ack edge: owner's `DataOut` ← `romDataIn`, owner's `ReadyOut` toggles, → IDLE. Non-owner outputs unchanged. Otherwise the counter increments.
- Watchdog: if the counter reaches `TIMEOUT-1` in WAIT without ack, then on the next edge `timeoutErr` ← 1 and → ERR. If ack and timeout coincide, ack wins.
- ERR: terminal until `rst`. No ROM trigger toggles. Owner's ready never toggles. Requests are ignored.
- New requests arriving during WAIT stay pending; they are evaluated in the next IDLE cycle.
- Counter width `$clog2(TIMEOUT)`. It saturates and never wraps.

## Timing
- Reset values: `fDataOut`=0, `lDataOut`=0, `fReadyOut`=0, `lReadyOut`=0, `romTriggerOut`=0, `romAddrOut`=0, `grantLoad`=1, `timeoutErr`=0, state IDLE, counter 0.
- Because `grantLoad` resets to 1, fetch wins the first simultaneous contest.
- Request visible before edge k: `romTriggerOut` toggles after edge k.
- ROM ack visible before edge j (j ≥ k+1): data and owner ready are updated after edge j.
- Next grant, if a request is pending: after edge j+1.
- Minimum 2 cycles per access. A same-cycle (combinational) ROM ack gives back-to-back accesses every 2 cycles.
- `rst` mid-WAIT abandons the access: no ready toggle, outputs go to reset values. The ROM and both requesters must be reset in the same cycle so all toggle phases restart at 0. A stale `romReadyIn`=1 after reset is a system error, not handled here.
- `romReadyIn` is ignored in IDLE and ERR.

## Test plan
- Single fetch: after reset, fetch toggles `fTriggerIn` with `fAddrIn`=0x10 and the ROM acks 1 cycle later with 0xE3A00001. Required: `romAddrOut`=0x10, `romTriggerOut`=1 after edge 1, `fDataOut`=0xE3A00001, `fReadyOut`=1 after edge 2, `grantLoad`=0.
- Simultaneous requests: both toggle in the same cycle (fetch 0x20, load 0x40). Required: fetch served first, then load. `lDataOut` holds ROM[0x40]. `fDataOut` is unchanged by the load access.
- Fairness: both requesters re-request continuously for 6 accesses. Required: grants alternate F,L,F,L,F,L and each ready toggles exactly 3 times.
- Slow ROM: ack delayed 10 cycles. Required: no extra ROM trigger toggles, data captured on ack+1, and a load request arriving mid-WAIT is granted 1 cycle after completion.
- Watchdog (`TIMEOUT`=8): ROM never acks. Required: `timeoutErr`=1 exactly 8 cycles after the grant edge, ERR held, and no further `romTriggerOut` toggles despite new requests. `rst` clears everything to reset values.
- Reset mid-access: assert `rst` 3 cycles into WAIT. Required: all outputs at reset values on the next edge, and a fresh fetch afterwards completes normally.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake ROM between fetch and load
// requesters, with a sticky watchdog that parks the block if the ROM hangs.
module rom_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fTriggerIn,
  input  logic [ADDR_W-1:0] fAddrIn,
  output logic [DATA_W-1:0] fDataOut,
  output logic              fReadyOut,
  input  logic              lTriggerIn,
  input  logic [ADDR_W-1:0] lAddrIn,
  output logic [DATA_W-1:0] lDataOut,
  output logic              lReadyOut,
  output logic              romTriggerOut,
  output logic [ADDR_W-1:0] romAddrOut,
  input  logic [DATA_W-1:0] romDataIn,
  input  logic              romReadyIn,
  output logic              grantLoad,
  output logic              timeoutErr,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ERR = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_wd_cnt;
  logic [DATA_W-1:0] r_f_data;
  logic [DATA_W-1:0] r_l_data;
  logic              r_f_ready;
  logic              r_l_ready;
  logic              r_rom_trig;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_grant_load;
  logic              r_err;

  logic w_f_pend;
  logic w_l_pend;
  logic w_pick_load;
  logic w_rom_ack;
  logic w_wd_expired;
  logic w_do_grant;
  logic w_do_ack;
  logic w_do_err;

  // Handshake: a side is pending while its trigger phase differs from its ready phase.
  assign w_f_pend     = fTriggerIn ^ r_f_ready;
  assign w_l_pend     = lTriggerIn ^ r_l_ready;
  assign w_pick_load  = (w_f_pend && w_l_pend) ? ~r_grant_load : w_l_pend;
  assign w_rom_ack    = (romReadyIn == r_rom_trig);
  assign w_wd_expired = (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_f_pend || w_l_pend) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_rom_ack)         w_next_state = ST_IDLE;
        else if (w_wd_expired) w_next_state = ST_ERR;
      end
      ST_ERR:  w_next_state = ST_ERR;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Ack takes priority over the watchdog when both happen in the same cycle.
  always_comb begin
    w_do_grant = 1'b0;
    w_do_ack   = 1'b0;
    w_do_err   = 1'b0;
    case (r_state)
      ST_IDLE: w_do_grant = w_f_pend || w_l_pend;
      ST_WAIT: begin
        w_do_ack = w_rom_ack;
        w_do_err = !w_rom_ack && w_wd_expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt     <= '0;
      r_f_data     <= '0;
      r_l_data     <= '0;
      r_f_ready    <= 1'b0;
      r_l_ready    <= 1'b0;
      r_rom_trig   <= 1'b0;
      r_rom_addr   <= '0;
      r_grant_load <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      if (w_do_grant) begin
        r_rom_addr   <= w_pick_load ? lAddrIn : fAddrIn;
        r_rom_trig   <= ~r_rom_trig;
        r_grant_load <= w_pick_load;
        r_wd_cnt     <= '0;
      end
      if (w_do_ack) begin
        if (r_grant_load) begin
          r_l_data  <= romDataIn;
          r_l_ready <= ~r_l_ready;
        end else begin
          r_f_data  <= romDataIn;
          r_f_ready <= ~r_f_ready;
        end
      end else if (r_state == ST_WAIT && !w_wd_expired) begin
        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
      if (w_do_err) r_err <= 1'b1;
    end
  end

  assign fDataOut      = r_f_data;
  assign fReadyOut     = r_f_ready;
  assign lDataOut      = r_l_data;
  assign lReadyOut     = r_l_ready;
  assign romTriggerOut = r_rom_trig;
  assign romAddrOut    = r_rom_addr;
  assign grantLoad     = r_grant_load;
  assign timeoutErr    = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a main instance (TIMEOUT=64) served by a
// behavioural ROM, plus a TIMEOUT=8 instance on the same inputs for the watchdog.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_trig = 1'b0;
  logic [31:0] f_addr = '0;
  logic        l_trig = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] rom_data = '0;
  logic        rom_ready = 1'b0;

  logic [31:0] f_data, l_data, rom_addr;
  logic        f_ready, l_ready, rom_trig, grant_load, err;
  logic [1:0]  dbg;

  logic [31:0] f_data2, l_data2, rom_addr2;
  logic        f_ready2, l_ready2, rom_trig2, grant_load2, err2;
  logic [1:0]  dbg2;

  int n_checks = 0;
  int n_pass   = 0;

  int rom_delay = 0;
  bit rom_en    = 1'b1;
  int rom_cnt   = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst),
    .fTriggerIn(f_trig), .fAddrIn(f_addr), .fDataOut(f_data), .fReadyOut(f_ready),
    .lTriggerIn(l_trig), .lAddrIn(l_addr), .lDataOut(l_data), .lReadyOut(l_ready),
    .romTriggerOut(rom_trig), .romAddrOut(rom_addr),
    .romDataIn(rom_data), .romReadyIn(rom_ready),
    .grantLoad(grant_load), .timeoutErr(err), .o_dbg_state(dbg)
  );

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut_wd (
    .clk(clk), .rst(rst),
    .fTriggerIn(f_trig), .fAddrIn(f_addr), .fDataOut(f_data2), .fReadyOut(f_ready2),
    .lTriggerIn(l_trig), .lAddrIn(l_addr), .lDataOut(l_data2), .lReadyOut(l_ready2),
    .romTriggerOut(rom_trig2), .romAddrOut(rom_addr2),
    .romDataIn(rom_data), .romReadyIn(rom_ready),
    .grantLoad(grant_load2), .timeoutErr(err2), .o_dbg_state(dbg2)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A00001;
    return {16'hC0DE, a[15:0]};
  endfunction

  // ROM model: answers the main instance after rom_delay extra falling edges.
  always @(negedge clk) begin
    if (rst) begin
      rom_ready = 1'b0;
      rom_cnt   = 0;
    end else if (rom_en && (rom_trig != rom_ready)) begin
      if (rom_cnt >= rom_delay) begin
        rom_data  = rom_word(rom_addr);
        rom_ready = rom_trig;
        rom_cnt   = 0;
      end else begin
        rom_cnt = rom_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    f_trig = 1'b0;
    l_trig = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [5:0] seq;
    int n_grant, f_tog, l_tog, f_req, l_req, bad;
    logic prev_trig, prev_fr, prev_lr;

    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_f_data", f_data, 32'h0);
    chk("rst_l_data", l_data, 32'h0);
    chk("rst_f_ready", {31'b0, f_ready}, 32'h0);
    chk("rst_l_ready", {31'b0, l_ready}, 32'h0);
    chk("rst_rom_trig", {31'b0, rom_trig}, 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_grant", {31'b0, grant_load}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_state", {30'b0, dbg}, 32'h0);

    // Single fetch
    rom_delay = 0;
    f_addr = 32'h10;
    f_trig = 1'b1;
    tick();
    chk("sf_rom_addr", rom_addr, 32'h10);
    chk("sf_rom_trig", {31'b0, rom_trig}, 32'h1);
    chk("sf_grant", {31'b0, grant_load}, 32'h0);
    chk("sf_ready_early", {31'b0, f_ready}, 32'h0);
    tick();
    chk("sf_f_data", f_data, 32'hE3A00001);
    chk("sf_f_ready", {31'b0, f_ready}, 32'h1);
    chk("sf_state_idle", {30'b0, dbg}, 32'h0);

    // Simultaneous requests: fetch wins the first contest after reset
    do_reset();
    f_addr = 32'h20; f_trig = 1'b1;
    l_addr = 32'h40; l_trig = 1'b1;
    tick();
    chk("sim_grant1", {31'b0, grant_load}, 32'h0);
    chk("sim_addr1", rom_addr, 32'h20);
    tick();
    chk("sim_f_data", f_data, 32'hC0DE0020);
    chk("sim_f_ready", {31'b0, f_ready}, 32'h1);
    chk("sim_l_ready_wait", {31'b0, l_ready}, 32'h0);
    tick();
    chk("sim_grant2", {31'b0, grant_load}, 32'h1);
    chk("sim_addr2", rom_addr, 32'h40);
    chk("sim_trig2", {31'b0, rom_trig}, 32'h0);
    tick();
    chk("sim_l_data", l_data, 32'hC0DE0040);
    chk("sim_l_ready", {31'b0, l_ready}, 32'h1);
    chk("sim_f_data_kept", f_data, 32'hC0DE0020);
    chk("sim_f_ready_kept", {31'b0, f_ready}, 32'h1);

    // Fairness: both re-request continuously for 3 accesses each
    do_reset();
    f_addr = 32'h24; l_addr = 32'h44;
    f_trig = 1'b1; l_trig = 1'b1;
    f_req = 1; l_req = 1;
    seq = '0; n_grant = 0; f_tog = 0; l_tog = 0;
    prev_trig = rom_trig; prev_fr = f_ready; prev_lr = l_ready;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rom_trig != prev_trig) begin
        seq = {seq[4:0], grant_load};
        n_grant++;
        prev_trig = rom_trig;
      end
      if (f_ready != prev_fr) begin f_tog++; prev_fr = f_ready; end
      if (l_ready != prev_lr) begin l_tog++; prev_lr = l_ready; end
      if (f_trig == f_ready && f_req < 3) begin f_trig = ~f_trig; f_req++; end
      if (l_trig == l_ready && l_req < 3) begin l_trig = ~l_trig; l_req++; end
    end
    chk("fair_n_grant", n_grant, 32'd6);
    chk("fair_seq", {26'b0, seq}, 32'b010101);
    chk("fair_f_toggles", f_tog, 32'd3);
    chk("fair_l_toggles", l_tog, 32'd3);

    // Slow ROM with a load request arriving mid-WAIT
    do_reset();
    rom_delay = 10;
    f_addr = 32'h30; f_trig = 1'b1;
    tick();
    chk("slow_grant", {31'b0, rom_trig}, 32'h1);
    bad = 0;
    for (int e = 2; e <= 11; e++) begin
      tick();
      if (rom_trig !== 1'b1 || f_ready !== 1'b0 || l_ready !== 1'b0) bad++;
      if (e == 4) begin
        l_addr = 32'h50;
        l_trig = 1'b1;
      end
    end
    chk("slow_wait_stable", bad, 32'd0);
    tick();
    chk("slow_f_data", f_data, 32'hC0DE0030);
    chk("slow_f_ready", {31'b0, f_ready}, 32'h1);
    chk("slow_no_early_grant", {31'b0, rom_trig}, 32'h1);
    rom_delay = 0;
    tick();
    chk("slow_l_grant", {31'b0, grant_load}, 32'h1);
    chk("slow_l_trig", {31'b0, rom_trig}, 32'h0);
    chk("slow_l_addr", rom_addr, 32'h50);
    tick();
    chk("slow_l_data", l_data, 32'hC0DE0050);
    chk("slow_l_ready", {31'b0, l_ready}, 32'h1);

    // Watchdog on the TIMEOUT=8 instance: ROM never answers
    do_reset();
    rom_en = 1'b0;
    f_addr = 32'h60; f_trig = 1'b1;
    tick();
    chk("wd_grant", {31'b0, rom_trig2}, 32'h1);
    for (int e = 2; e <= 8; e++) tick();
    chk("wd_err_not_yet", {31'b0, err2}, 32'h0);
    tick();
    chk("wd_err_set", {31'b0, err2}, 32'h1);
    chk("wd_state_err", {30'b0, dbg2}, 32'h2);
    l_addr = 32'h80; l_trig = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    chk("wd_err_held", {31'b0, err2}, 32'h1);
    chk("wd_no_retrigger", {31'b0, rom_trig2}, 32'h1);
    chk("wd_no_f_ready", {31'b0, f_ready2}, 32'h0);
    chk("wd_no_l_ready", {31'b0, l_ready2}, 32'h0);
    chk("wd_state_held", {30'b0, dbg2}, 32'h2);
    do_reset();
    rom_en = 1'b1;
    chk("wd_rst_err", {31'b0, err2}, 32'h0);
    chk("wd_rst_trig", {31'b0, rom_trig2}, 32'h0);
    chk("wd_rst_grant", {31'b0, grant_load2}, 32'h1);
    chk("wd_rst_addr", rom_addr2, 32'h0);
    chk("wd_rst_state", {30'b0, dbg2}, 32'h0);

    // Reset three cycles into WAIT abandons the access
    rom_delay = 0;
    f_addr = 32'h10; f_trig = 1'b1;
    tick();
    tick();
    chk("ra_pre_data", f_data, 32'hE3A00001);
    rom_delay = 20;
    f_addr = 32'h70; f_trig = 1'b0;
    tick();
    chk("ra_grant", rom_addr, 32'h70);
    tick(); tick(); tick();
    rst = 1'b1; f_trig = 1'b0; l_trig = 1'b0;
    tick();
    chk("ra_f_data", f_data, 32'h0);
    chk("ra_f_ready", {31'b0, f_ready}, 32'h0);
    chk("ra_rom_trig", {31'b0, rom_trig}, 32'h0);
    chk("ra_rom_addr", rom_addr, 32'h0);
    chk("ra_grant_load", {31'b0, grant_load}, 32'h1);
    chk("ra_state", {30'b0, dbg}, 32'h0);
    tick();
    rst = 1'b0;
    rom_delay = 0;
    f_addr = 32'h10; f_trig = 1'b1;
    tick();
    chk("ra_new_trig", {31'b0, rom_trig}, 32'h1);
    chk("ra_new_addr", rom_addr, 32'h10);
    tick();
    chk("ra_new_data", f_data, 32'hE3A00001);
    chk("ra_new_ready", {31'b0, f_ready}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
